// File: rtl/fadd_pipe.sv
// Three-stage floating-point adder/subtractor: align, add/normalise, round/pack.
// Subnormal inputs flush to zero. Special results are resolved at entry and carried as a bypass word.
module fadd_pipe #(
    parameter int EW = 8,
    parameter int MW = 23
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [EW+MW:0] x1,
    input  logic [EW+MW:0] x2,
    input  logic           sub,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [EW+MW:0] y,
    output logic           ovf,
    output logic           udf
);
    localparam int SW = MW + 4;
    localparam logic [EW-1:0]        EONES = '1;
    localparam logic signed [EW+1:0] EMAX  = {2'b00, EONES};
    localparam logic signed [EW+1:0] EONE  = {{(EW+1){1'b0}}, 1'b1};
    localparam logic [EW+MW:0]       QNAN  = {1'b0, EONES, 1'b1, {(MW-1){1'b0}}};

    logic stall, en;
    assign stall    = out_valid && !out_ready;
    assign en       = !stall;
    assign in_ready = en;

    logic [EW-1:0]   e1, e2, eb, es;
    logic [MW-1:0]   f1, f2, fb, fs;
    logic            s1, s2, nan1, nan2, inf1, inf2, x1_big, sp_in;
    logic [EW+MW:0]  spv_in;
    logic [31:0]     dexp, shamt;
    logic [2*SW-1:0] wide;
    logic [SW-1:0]   sig_b, sig_a;

    always_comb begin
        e1     = x1[EW+MW-1:MW];
        e2     = x2[EW+MW-1:MW];
        f1     = (e1 == '0) ? '0 : x1[MW-1:0];
        f2     = (e2 == '0) ? '0 : x2[MW-1:0];
        s1     = x1[EW+MW];
        s2     = x2[EW+MW] ^ sub;
        nan1   = (e1 == EONES) && (f1 != '0);
        nan2   = (e2 == EONES) && (f2 != '0);
        inf1   = (e1 == EONES) && (f1 == '0);
        inf2   = (e2 == EONES) && (f2 == '0);
        sp_in  = nan1 | nan2 | inf1 | inf2;
        if (nan1 || nan2 || (inf1 && inf2 && (s1 != s2)))
            spv_in = QNAN;
        else if (inf1)
            spv_in = {s1, EONES, {MW{1'b0}}};
        else
            spv_in = {s2, EONES, {MW{1'b0}}};
        x1_big = {e1, f1} >= {e2, f2};
        eb     = x1_big ? e1 : e2;
        es     = x1_big ? e2 : e1;
        fb     = x1_big ? f1 : f2;
        fs     = x1_big ? f2 : f1;
        dexp   = 32'(eb) - 32'(es);
        shamt  = (dexp > 32'(SW)) ? 32'(SW) : dexp;
        sig_b  = {(eb != '0), fb, 3'b000};
        // The low half of the wide shift catches every bit that falls off the field.
        wide   = {(es != '0), fs, 3'b000, {SW{1'b0}}} >> shamt;
        sig_a  = {wide[2*SW-1:SW+1], wide[SW] | (|wide[SW-1:0])};
    end

    logic           v1, sp1, sg1, op1;
    logic [EW+MW:0] spv1;
    logic [EW-1:0]  ex1;
    logic [SW-1:0]  mb1, ma1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1   <= 1'b0;
            sp1  <= 1'b0;
            spv1 <= '0;
            sg1  <= 1'b0;
            op1  <= 1'b0;
            ex1  <= '0;
            mb1  <= '0;
            ma1  <= '0;
        end else if (en) begin
            v1   <= in_valid;
            sp1  <= sp_in;
            spv1 <= spv_in;
            sg1  <= x1_big ? s1 : s2;
            op1  <= s1 != s2;
            ex1  <= eb;
            mb1  <= sig_b;
            ma1  <= sig_a;
        end
    end

    logic [SW:0]             sum;
    logic [SW-1:0]           nsig;
    logic signed [EW+1:0]    nexp;
    int                      lzc;
    logic                    found;

    always_comb begin
        sum   = op1 ? ({1'b0, mb1} - {1'b0, ma1}) : ({1'b0, mb1} + {1'b0, ma1});
        lzc   = 0;
        found = 1'b0;
        for (int i = SW - 1; i >= 0; i--) begin
            if (!found) begin
                if (sum[i]) found = 1'b1;
                else        lzc   = lzc + 1;
            end
        end
        if (sum[SW]) begin
            nsig = {sum[SW:2], sum[1] | sum[0]};
            nexp = {2'b00, ex1} + EONE;
        end else begin
            nsig = sum[SW-1:0] << lzc;
            nexp = {2'b00, ex1} - (EW+2)'(lzc);
        end
    end

    logic                 v2, sp2, sg2, zr2;
    logic [EW+MW:0]       spv2;
    logic signed [EW+1:0] ex2;
    logic [SW-1:0]        sig2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2   <= 1'b0;
            sp2  <= 1'b0;
            spv2 <= '0;
            sg2  <= 1'b0;
            zr2  <= 1'b0;
            ex2  <= '0;
            sig2 <= '0;
        end else if (en) begin
            v2   <= v1;
            sp2  <= sp1;
            spv2 <= spv1;
            // Exact cancellation of opposite signs gives +0.
            sg2  <= ((sum == '0) && op1) ? 1'b0 : sg1;
            zr2  <= sum == '0;
            ex2  <= nexp;
            sig2 <= nsig;
        end
    end

    logic                 inc, ovf_n, udf_n;
    logic [MW+1:0]        rnd;
    logic [MW-1:0]        frac;
    logic signed [EW+1:0] rexp;
    logic [EW+MW:0]       y_n;

    always_comb begin
        inc   = sig2[2] & (sig2[1] | sig2[0] | sig2[3]);
        rnd   = {1'b0, sig2[SW-1:3]} + {{(MW+1){1'b0}}, inc};
        if (rnd[MW+1]) begin
            frac = rnd[MW:1];
            rexp = ex2 + EONE;
        end else begin
            frac = rnd[MW-1:0];
            rexp = ex2;
        end
        ovf_n = 1'b0;
        udf_n = 1'b0;
        if (sp2) begin
            y_n = spv2;
        end else if (zr2) begin
            y_n = {sg2, {(EW+MW){1'b0}}};
        end else if (rexp >= EMAX) begin
            y_n   = {sg2, EONES, {MW{1'b0}}};
            ovf_n = 1'b1;
        end else if (rexp[EW+1] || (rexp == '0)) begin
            y_n   = {sg2, {(EW+MW){1'b0}}};
            udf_n = 1'b1;
        end else begin
            y_n = {sg2, rexp[EW-1:0], frac};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            y         <= '0;
            ovf       <= 1'b0;
            udf       <= 1'b0;
        end else if (en) begin
            out_valid <= v2;
            if (v2) begin
                y   <= y_n;
                ovf <= ovf_n;
                udf <= udf_n;
            end
        end
    end
endmodule
